eager_broadcaster: RTL and testbench

EAGER_BROADCASTER -- requirements
Module: eager_broadcaster

---
 rtl/broadcast_pkg.sv | 15 +
 rtl/channel_skid_buffer.sv | 88 ++++++++
 rtl/eager_broadcaster.sv | 81 ++++++++
 tb/tb_eager_broadcaster.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/broadcast_pkg.sv
// rtl/broadcast_pkg.sv - shared constants for the eager broadcaster and its channel buffers
package broadcast_pkg;

  // Legal values of the BURST parameter
  localparam string BURST_YES = "yes";
  localparam string BURST_NO  = "no";

  // Largest supported channel count
  localparam int MAX_NCH = 8;

  // Stall counter width and its saturation value
  localparam int                    STALL_CNT_W   = 16;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

endpackage

// File: rtl/channel_skid_buffer.sv
// rtl/channel_skid_buffer.sv - per-channel output buffer, 2-entry skid (BURST "yes") or 1-entry register
module channel_skid_buffer
  import broadcast_pkg::*;
#(
  parameter int    WIDTH = 32,
  parameter string BURST = "yes"
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_free,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic w_drain;
  assign w_drain = o_valid && i_ready;

  generate
    if (BURST == BURST_YES) begin : g_burst
      logic [WIDTH-1:0] r_head;
      logic [WIDTH-1:0] r_tail;
      logic [1:0]       r_cnt;

      // Two-entry FIFO: head drives the output, tail catches a load while the head is held
      always_ff @(posedge iCLK) begin
        if (iRST) begin
          r_head <= '0;
          r_tail <= '0;
          r_cnt  <= 2'd0;
        end else begin
          case (r_cnt)
            2'd0: begin
              if (i_load) begin
                r_head <= i_data;
                r_cnt  <= 2'd1;
              end
            end
            2'd1: begin
              if (w_drain && i_load) begin
                r_head <= i_data;
              end else if (w_drain) begin
                r_cnt <= 2'd0;
              end else if (i_load) begin
                r_tail <= i_data;
                r_cnt  <= 2'd2;
              end
            end
            default: begin
              if (w_drain) begin
                r_head <= r_tail;
                r_cnt  <= 2'd1;
              end
            end
          endcase
        end
      end

      // Free is derived from registered occupancy only, so downstream ready never reaches upstream ready
      assign o_free  = (r_cnt != 2'd2);
      assign o_valid = (r_cnt != 2'd0);
      assign o_data  = r_head;
    end else begin : g_single
      logic [WIDTH-1:0] r_data;
      logic             r_valid;

      // Single register: accepts only when empty, so a token occupies it for at least two cycles
      always_ff @(posedge iCLK) begin
        if (iRST) begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end else if (i_load) begin
          r_data  <= i_data;
          r_valid <= 1'b1;
        end else if (w_drain) begin
          r_valid <= 1'b0;
        end
      end

      assign o_free  = !r_valid;
      assign o_valid = r_valid;
      assign o_data  = r_data;
    end
  endgenerate

endmodule

// File: rtl/eager_broadcaster.sv
// rtl/eager_broadcaster.sv - eager fork of one token to masked channels; stall counter under EAGER_BROADCASTER_STALL_CNT_EN
module eager_broadcaster
  import broadcast_pkg::*;
#(
  parameter int    NCH   = 2,
  parameter int    WIDTH = 32,
  parameter string BURST = "yes"
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iValid_AM,
  output logic                 oReady_AM,
  input  logic [NCH*WIDTH-1:0] iData_AM,
  input  logic [NCH-1:0]       iMask_AM,
  output logic [NCH-1:0]       oValid_BM,
  input  logic [NCH-1:0]       iReady_BM,
  output logic [NCH*WIDTH-1:0] oData_BM
`ifdef EAGER_BROADCASTER_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] oStall_CNT
`endif
);

  logic [NCH-1:0] rSent;
  logic [NCH-1:0] w_free;
  logic [NCH-1:0] w_load;
  logic [NCH-1:0] w_done;
  logic           w_accept;

  // A channel is satisfied if it is not targeted, already has the token, or can take it now
  assign w_done    = ~iMask_AM | rSent | w_free;
  assign oReady_AM = &w_done;
  assign w_load    = {NCH{iValid_AM}} & iMask_AM & ~rSent & w_free;
  assign w_accept  = iValid_AM && oReady_AM;

  // Remember which channels already captured the current token; forget once the token retires
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rSent <= '0;
    end else if (w_accept) begin
      rSent <= '0;
    end else begin
      rSent <= rSent | w_load;
    end
  end

  genvar k;
  generate
    for (k = 0; k < NCH; k++) begin : g_ch
      channel_skid_buffer #(
        .WIDTH (WIDTH),
        .BURST (BURST)
      ) u_ch (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .i_load  (w_load[k]),
        .i_data  (iData_AM[k*WIDTH +: WIDTH]),
        .o_free  (w_free[k]),
        .o_valid (oValid_BM[k]),
        .i_ready (iReady_BM[k]),
        .o_data  (oData_BM[k*WIDTH +: WIDTH])
      );
    end
  endgenerate

`ifdef EAGER_BROADCASTER_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] r_stall;

  // Count cycles upstream is offering a token that cannot retire yet, saturating at the top
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_stall <= '0;
    end else if (iValid_AM && !oReady_AM && (r_stall != STALL_CNT_MAX)) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign oStall_CNT = r_stall;
`endif

endmodule

// File: tb/tb_eager_broadcaster.sv
// tb/tb_eager_broadcaster.sv - randomized self-checking bench for eager_broadcaster, BURST "no" and "yes"
module tb_eager_broadcaster;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0: BURST "no" instance, index 1: BURST "yes" instance
  logic        rst [2];
  logic        v   [2];
  logic [2:0]  m   [2];
  logic [23:0] dat [2];
  logic [2:0]  rdy [2];
  logic        or_ [2];
  logic [2:0]  ov  [2];
  logic [23:0] od  [2];
`ifdef EAGER_BROADCASTER_STALL_CNT_EN
  logic [15:0] stall [2];
`endif

  eager_broadcaster #(.NCH(3), .WIDTH(8), .BURST("no")) dut_n (
    .iCLK(clk), .iRST(rst[0]), .iValid_AM(v[0]), .oReady_AM(or_[0]),
    .iData_AM(dat[0]), .iMask_AM(m[0]), .oValid_BM(ov[0]),
    .iReady_BM(rdy[0]), .oData_BM(od[0])
`ifdef EAGER_BROADCASTER_STALL_CNT_EN
    , .oStall_CNT(stall[0])
`endif
  );

  eager_broadcaster #(.NCH(3), .WIDTH(8), .BURST("yes")) dut_y (
    .iCLK(clk), .iRST(rst[1]), .iValid_AM(v[1]), .oReady_AM(or_[1]),
    .iData_AM(dat[1]), .iMask_AM(m[1]), .oValid_BM(ov[1]),
    .iReady_BM(rdy[1]), .oData_BM(od[1])
`ifdef EAGER_BROADCASTER_STALL_CNT_EN
    , .oStall_CNT(stall[1])
`endif
  );

  // Reference model: per-channel ordered token lists with a capacity, plus a delivered-set per token
  logic [7:0]  mbuf   [2][3][2];
  int          mcnt   [2][3];
  logic [2:0]  msent  [2];
  logic [15:0] mstall [2];
  int          hs     [2][3];
  int          lowrdy [2];
  logic        last_rdy [2];
  bit          chk_on;
  int          total;
  int          bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model();
    for (int d = 0; d < 2; d++) begin
      logic       er;
      logic [2:0] ev;
      logic [2:0] fr;
      logic [2:0] ld;
      int         cap;
      cap = (d == 1) ? 2 : 1;
      er  = 1'b1;
      for (int k = 0; k < 3; k++) begin
        fr[k] = (mcnt[d][k] < cap);
        ev[k] = (mcnt[d][k] > 0);
        if (m[d][k] && !msent[d][k] && !fr[k]) er = 1'b0;
      end
      if (chk_on) begin
        check($sformatf("d%0d ready", d), 32'(or_[d]), 32'(er));
        check($sformatf("d%0d valid", d), 32'(ov[d]), 32'(ev));
        for (int k = 0; k < 3; k++)
          if (ev[k]) check($sformatf("d%0d data ch%0d", d, k), 32'(od[d][k*8 +: 8]), 32'(mbuf[d][k][0]));
`ifdef EAGER_BROADCASTER_STALL_CNT_EN
        check($sformatf("d%0d stall", d), 32'(stall[d]), 32'(mstall[d]));
`endif
      end
      for (int k = 0; k < 3; k++)
        if (ov[d][k] && rdy[d][k]) hs[d][k]++;
      if (v[d] && !or_[d]) lowrdy[d]++;
      last_rdy[d] = or_[d];
      if (rst[d]) begin
        for (int k = 0; k < 3; k++) mcnt[d][k] = 0;
        msent[d]  = '0;
        mstall[d] = '0;
      end else begin
        for (int k = 0; k < 3; k++) begin
          ld[k] = v[d] && m[d][k] && !msent[d][k] && fr[k];
          if (ev[k] && rdy[d][k]) begin
            mbuf[d][k][0] = mbuf[d][k][1];
            mcnt[d][k]--;
          end
          if (ld[k]) begin
            mbuf[d][k][mcnt[d][k]] = dat[d][k*8 +: 8];
            mcnt[d][k]++;
          end
        end
        if (v[d] && er) msent[d] = '0;
        else msent[d] = msent[d] | ld;
        if (v[d] && !er && mstall[d] != 16'hFFFF) mstall[d] = mstall[d] + 16'd1;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    adv();
  endtask

  task automatic drive_rand(input int d);
    if (!(v[d] && !last_rdy[d])) begin
      v[d]   = ($urandom % 4) != 0;
      m[d]   = 3'($urandom);
      dat[d] = 24'($urandom);
    end
    rdy[d] = 3'($urandom);
    rst[d] = ($urandom % 256) == 0;
  endtask

  int h0 [3];
  int lr0;
  logic [15:0] s0;
  int wait_cnt;

  initial begin
    total = 0;
    bad   = 0;
    chk_on = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; v[d] = 1'b0; m[d] = '0; dat[d] = '0; rdy[d] = 3'b111;
      last_rdy[d] = 1'b0; lowrdy[d] = 0; msent[d] = '0; mstall[d] = '0;
      for (int k = 0; k < 3; k++) begin mcnt[d][k] = 0; hs[d][k] = 0; end
    end
    s0 = '0;
    adv();
    tick();
    tick();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    chk_on = 1'b1;

    // Reset state
    sample();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset valid d%0d", d), 32'(ov[d]), 32'h0);
      check($sformatf("reset data d%0d", d), 32'(od[d]), 32'h0);
      check($sformatf("reset ready d%0d", d), 32'(or_[d]), 32'h1);
    end
    adv();

    // Broadcast to all channels, all ready
    v[1] = 1'b1; m[1] = 3'b111; dat[1] = 24'h332211; rdy[1] = 3'b111;
    sample();
    check("all ready same cycle", 32'(or_[1]), 32'h1);
    adv();
    v[1] = 1'b0;
    sample();
    check("all valid next cycle", 32'(ov[1]), 32'h7);
    check("all data next cycle", 32'(od[1]), 32'h332211);
    adv();

    // Single destination
    v[1] = 1'b1; m[1] = 3'b010; dat[1] = 24'hAABBCC;
    tick();
    v[1] = 1'b0;
    sample();
    check("mask010 valid", 32'(ov[1]), 32'h2);
    check("mask010 data", 32'(od[1][15:8]), 32'hBB);
    adv();

    // Empty mask is dropped immediately
`ifdef EAGER_BROADCASTER_STALL_CNT_EN
    s0 = stall[1];
`endif
    v[1] = 1'b1; m[1] = 3'b000; dat[1] = 24'h123456;
    sample();
    check("mask000 ready", 32'(or_[1]), 32'h1);
    adv();
    v[1] = 1'b0;
    sample();
    check("mask000 no valid", 32'(ov[1]), 32'h0);
`ifdef EAGER_BROADCASTER_STALL_CNT_EN
    check("mask000 stall unchanged", 32'(stall[1]), 32'(s0));
`endif
    adv();

    // BURST "no": ch1 occupied and not ready for 4 cycles
    for (int k = 0; k < 3; k++) h0[k] = hs[0][k];
    rdy[0] = 3'b101; v[0] = 1'b1; m[0] = 3'b010; dat[0] = 24'h005A00;
    sample();
    check("blk prefill ready", 32'(or_[0]), 32'h1);
    adv();
    m[0] = 3'b111; dat[0] = 24'h3C4B2D;
    sample();
    check("blk ready low B", 32'(or_[0]), 32'h0);
    adv();
    sample();
    check("blk ready low C", 32'(or_[0]), 32'h0);
    check("blk valid C", 32'(ov[0]), 32'h7);
    check("blk rSent C", 32'(dut_n.rSent), 32'h5);
    adv();
    sample();
    check("blk valid D", 32'(ov[0]), 32'h2);
    adv();
    rdy[0] = 3'b111;
    sample();
    check("blk ready low E", 32'(or_[0]), 32'h0);
    adv();
    sample();
    check("blk ready rises F", 32'(or_[0]), 32'h1);
    adv();
    v[0] = 1'b0;
    sample();
    check("blk ch1 valid G", 32'(ov[0]), 32'h2);
    check("blk ch1 data G", 32'(od[0][15:8]), 32'h4B);
    adv();
    check("blk ch0 once", 32'(hs[0][0] - h0[0]), 32'd1);
    check("blk ch1 twice", 32'(hs[0][1] - h0[1]), 32'd2);
    check("blk ch2 once", 32'(hs[0][2] - h0[2]), 32'd1);

    // Reset while token partially delivered (BURST "yes")
    rdy[1] = 3'b011; v[1] = 1'b1; m[1] = 3'b100; dat[1] = 24'h010000;
    tick();
    dat[1] = 24'h020000;
    tick();
    m[1] = 3'b111; dat[1] = 24'h037766;
    sample();
    check("rst pre ready low", 32'(or_[1]), 32'h0);
    adv();
    sample();
    check("rst pre rSent", 32'(dut_y.rSent), 32'h3);
    adv();
    rst[1] = 1'b1; v[1] = 1'b0;
    tick();
    rst[1] = 1'b0; rdy[1] = 3'b111;
    sample();
    check("rst post valid", 32'(ov[1]), 32'h0);
    check("rst post data", 32'(od[1]), 32'h0);
    check("rst post rSent", 32'(dut_y.rSent), 32'h0);
`ifdef EAGER_BROADCASTER_STALL_CNT_EN
    check("rst post stall", 32'(stall[1]), 32'h0);
`endif
    adv();

    // 100 back-to-back tokens, BURST "yes", all ready
    for (int k = 0; k < 3; k++) h0[k] = hs[1][k];
    lr0 = lowrdy[1];
    m[1] = 3'b111; rdy[1] = 3'b111;
    for (int i = 0; i < 100; i++) begin
      v[1] = 1'b1;
      dat[1] = 24'($urandom);
      tick();
    end
    v[1] = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("b2b never stalled", 32'(lowrdy[1] - lr0), 32'd0);
    for (int k = 0; k < 3; k++)
      check($sformatf("b2b count ch%0d", k), 32'(hs[1][k] - h0[k]), 32'd100);

    // Bounded drain of the BURST "no" instance before random traffic
    wait_cnt = 0;
    rdy[0] = 3'b111;
    while (ov[0] != 3'b000 && wait_cnt < 20) begin
      tick();
      wait_cnt++;
    end
    check("drain bound", 32'(wait_cnt < 20), 32'h1);

    // Randomized traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      drive_rand(0);
      drive_rand(1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
